// File: rtl/operand_sel_pipe.sv
// N-to-1 operand select feeding a registered pipeline stage with a valid/ready
// handshake and a one-entry skid buffer, so in_ready never depends on out_ready.
module operand_sel_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic [NUM_IN*WIDTH-1:0] in_data_i,
  input  logic [SEL_W-1:0]        in_sel_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [WIDTH-1:0]        out_data_o,
  output logic                    out_sel_err_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_err_q, out_err_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;

  logic accept;
  logic adv;

  // Unmatched select codes fall through to zero data with the error flag set.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel_i == SEL_W'(k)) begin
        sel_data = in_data_i[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  assign accept = in_valid_i & in_ready_q;
  assign adv    = ~out_valid_q | out_ready_i;

  always_comb begin
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;
    skid_valid_d = skid_valid_q;

    if (flush_i) begin
      out_valid_d  = 1'b0;
      out_err_d    = 1'b0;
      skid_valid_d = 1'b0;
      skid_err_d   = 1'b0;
    end else if (adv) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_err_d    = skid_err_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_data_d = sel_data;
          out_err_d  = sel_err;
        end
      end
    end else if (accept) begin
      skid_data_d  = sel_data;
      skid_err_d   = sel_err;
      skid_valid_d = 1'b1;
    end

    // Registered ready: computed from next skid occupancy.
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_data_o    = out_data_q;
  assign out_sel_err_o = out_err_q;
  assign out_valid_o   = out_valid_q;

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Directed bench for operand_sel_pipe (NUM_IN = 3): vector table for select and
// backpressure, plus hand sequences for throughput, flush and async reset.
module tb_operand_sel_pipe;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    flush;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_sel_err;
  logic                    out_valid;
  logic                    out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  operand_sel_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .in_data_i    (in_data),
    .in_sel_i     (in_sel),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .out_data_o   (out_data),
    .out_sel_err_o(out_sel_err),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic [1:0]  sel;
    logic [31:0] d0, d1, d2;
    logic        valid, ready;
    logic        ev;
    logic [31:0] ed;
    logic        ee;
    logic        er;
  } vec_t;

  vec_t vt[12];

  function automatic vec_t mk(logic [1:0] sel, logic [31:0] d0, logic [31:0] d1,
                              logic [31:0] d2, logic valid, logic ready, logic ev,
                              logic [31:0] ed, logic ee, logic er);
    vec_t v;
    v.flush = 1'b0; v.sel = sel; v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.valid = valid; v.ready = ready; v.ev = ev; v.ed = ed; v.ee = ee; v.er = er;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic fl, logic [1:0] sel, logic [31:0] d0, logic [31:0] d1,
                       logic [31:0] d2, logic valid, logic ready);
    flush = fl; in_sel = sel; in_data = {d2, d1, d0}; in_valid = valid; out_ready = ready;
  endtask

  initial begin
    logic [31:0] exp_q;

    vt[0]  = mk(2'd0, 32'h11, 32'h22, 32'h33, 1, 1, 1, 32'h11, 0, 1);
    vt[1]  = mk(2'd1, 32'h11, 32'h22, 32'h33, 1, 1, 1, 32'h22, 0, 1);
    vt[2]  = mk(2'd2, 32'h11, 32'h22, 32'h33, 1, 1, 1, 32'h33, 0, 1);
    vt[3]  = mk(2'd3, 32'h11, 32'h22, 32'h33, 1, 1, 1, 32'h00, 1, 1);
    vt[4]  = mk(2'd0, 32'h11, 32'h22, 32'h33, 0, 1, 0, 32'h00, 0, 1);
    // Backpressure: A to main, B to skid, C refused, then drain A,B,C,D.
    vt[5]  = mk(2'd0, 32'hA, 32'h0, 32'h0, 1, 0, 1, 32'hA, 0, 1);
    vt[6]  = mk(2'd1, 32'h0, 32'hB, 32'h0, 1, 0, 1, 32'hA, 0, 0);
    vt[7]  = mk(2'd2, 32'h0, 32'h0, 32'hC, 1, 0, 1, 32'hA, 0, 0);
    vt[8]  = mk(2'd2, 32'h0, 32'h0, 32'hC, 1, 1, 1, 32'hB, 0, 1);
    vt[9]  = mk(2'd2, 32'h0, 32'h0, 32'hC, 1, 1, 1, 32'hC, 0, 1);
    vt[10] = mk(2'd0, 32'hD, 32'h0, 32'h0, 1, 1, 1, 32'hD, 0, 1);
    vt[11] = mk(2'd0, 32'h0, 32'h0, 32'h0, 0, 1, 0, 32'h0, 0, 1);

    // Reset held with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
            $urandom_range(0, 1), $urandom_range(0, 1));
      step();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
    end
    drive(0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 1);
    #3 rst_n = 1'b1;
    step();
    drive(0, 2'd2, 32'h0, 32'h0, 32'hDEADBEEF, 1, 1);
    step();
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_data", out_data, 32'hDEADBEEF);
    check("first_err", 32'(out_sel_err), 32'd0);
    drive(0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 1);
    step();
    check("first_drain", 32'(out_valid), 32'd0);

    // Table vectors.
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].flush, vt[i].sel, vt[i].d0, vt[i].d1, vt[i].d2, vt[i].valid, vt[i].ready);
      step();
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].ev));
      check($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vt[i].er));
      if (vt[i].ev) begin
        check($sformatf("vec%0d_data", i), out_data, vt[i].ed);
        check($sformatf("vec%0d_err", i), 32'(out_sel_err), 32'(vt[i].ee));
      end
    end

    // Full throughput: every beat appears exactly one cycle after acceptance.
    for (int i = 0; i < 100; i++) begin
      logic [1:0] s;
      s = 2'(i % 3);
      exp_q = 32'h1000 * 32'(i) + 32'(s) + 32'h5;
      drive(0, s, (s == 0) ? exp_q : ~exp_q, (s == 1) ? exp_q : ~exp_q,
            (s == 2) ? exp_q : ~exp_q, 1, 1);
      step();
      check("tput_valid", 32'(out_valid), 32'd1);
      check("tput_data", out_data, exp_q);
      check("tput_ready", 32'(in_ready), 32'd1);
    end
    drive(0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 1);
    step();
    check("tput_idle", 32'(out_valid), 32'd0);

    // Flush with both registers full and a new beat offered.
    drive(0, 2'd3, 32'h0, 32'h0, 32'h0, 1, 0);
    step();
    check("fl_main_err", 32'(out_sel_err), 32'd1);
    drive(0, 2'd1, 32'h0, 32'h77, 32'h0, 1, 0);
    step();
    check("fl_full_ready", 32'(in_ready), 32'd0);
    drive(1, 2'd0, 32'h99, 32'h0, 32'h0, 1, 0);
    step();
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready), 32'd1);
    check("fl_err", 32'(out_sel_err), 32'd0);
    drive(0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_no_ghost", 32'(out_valid), 32'd0);
    end

    // Async reset while two beats are held.
    drive(0, 2'd0, 32'h5A, 32'h0, 32'h0, 1, 0);
    step();
    drive(0, 2'd2, 32'h0, 32'h0, 32'h6B, 1, 0);
    step();
    check("ar_held_valid", 32'(out_valid), 32'd1);
    check("ar_held_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_ready", 32'(in_ready), 32'd1);
    check("ar_data", out_data, 32'd0);
    drive(0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 1);
    step();
    #2 rst_n = 1'b1;
    step();
    check("ar_empty", 32'(out_valid), 32'd0);
    drive(0, 2'd1, 32'h0, 32'hC0FFEE, 32'h0, 1, 1);
    step();
    check("ar_new_valid", 32'(out_valid), 32'd1);
    check("ar_new_data", out_data, 32'hC0FFEE);
    drive(0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 1);
    step();
    check("ar_new_drain", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_sel_pipe.md
# operand_sel_pipe

Parametrised N-to-1 operand-select pipeline stage with valid/ready handshake and a one-entry skid buffer. It generalises the fixed 2:1 and 3:1 datapath multiplexers to any input count and width, and registers the selected word into the next pipeline stage. Out-of-range selects yield zero, matching the existing 3:1 default, and are flagged per beat. The stage sits between operand fetch/forwarding and the ALU input; flush supports branch-mispredict squashing.

## Interface
- WIDTH, 32, data word width in bits
- NUM_IN, 4, number of selectable inputs (2..16)
- SEL_W, $clog2(NUM_IN) (min 1), select field width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous squash of all held beats
- in_data  input  NUM_IN*WIDTH  packed inputs; input k = in_data[k*WIDTH +: WIDTH]
- in_sel  input  SEL_W  binary select of the input word
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage can accept a beat this cycle
- out_data  output  WIDTH  selected, registered word
- out_sel_err  output  1  beat in out_data was captured with in_sel >= NUM_IN
- out_valid  output  1  out_data holds a valid beat
- out_ready  input  1  downstream accepts the beat this cycle

## Operation
- Select: word = in_data[in_sel] when in_sel < NUM_IN, else all-zero with err = 1. Select logic is combinational; only the result is registered.
- Accept: beat transfers in when in_valid & in_ready. Emit: beat transfers out when out_valid & out_ready.
- State: main register (out_data, out_sel_err, out_valid) and skid register (skid_data, skid_err, skid_valid).
- in_ready = ~skid_valid, driven directly from a flop. No combinational path from out_ready to in_ready.
- Advance condition: adv = ~out_valid | out_ready.
- adv & skid_valid: main <= skid, skid_valid <= 0. No input is accepted this cycle because in_ready = 0.
- adv & ~skid_valid: main <= selected input; out_valid <= accept.
- ~adv & accept: skid <= selected input, skid_valid <= 1. Main holds.
- ~adv & ~accept: all state holds. out_data must stay stable while out_valid & ~out_ready.
- Beats leave in acceptance order; none is dropped or duplicated except by flush.
- flush = 1: out_valid <= 0, skid_valid <= 0, in_ready <= 1 next cycle. A beat accepted in the flush cycle is discarded. Flush overrides all other updates. Data registers may hold stale values, but out_sel_err is cleared.

## Timing
- Reset (rst = 0, asynchronous): out_valid = 0, out_data = 0, out_sel_err = 0, skid_valid = 0, in_ready = 1. Takes effect immediately, without a clock edge. Release is synchronous to the next clk edge.
- Reset asserted mid-transfer drops all held beats. Both registers are empty on release.
- Latency: an accepted beat appears on out_data/out_valid in the cycle after acceptance when main is empty or draining.
- Throughput: 1 beat/cycle sustained while out_ready = 1.
- Backpressure: the first beat arriving while main is stalled lands in skid. in_ready drops the following cycle. At most 2 beats are held.
- Recovery: on the first cycle out_ready = 1 after a stall, the skid beat moves to main and in_ready rises the next cycle.
- Simultaneous flush & out_ready & out_valid: the downstream does see the handshake, but the block treats the beat as squashed. The consumer must qualify with its own flush.
- Simultaneous accept & emit with skid empty: main reloads from input with no bubble.

## Test plan
- Reset/idle: hold rst = 0 with random inputs -> out_valid = 0, out_data = 0, in_ready = 1. Release, then in_sel = 2, in_data[2] = 0xDEADBEEF, in_valid = 1 -> next cycle out_data = 0xDEADBEEF, out_valid = 1, out_sel_err = 0.
- Select sweep (NUM_IN = 3, SEL_W = 2): in_sel = 0, 1, 2, 3 with inputs 0x11, 0x22, 0x33 -> outputs 0x11, 0x22, 0x33, then 0x0 with out_sel_err = 1 on the 4th beat only.
- Backpressure: stream beats A, B, C, D with out_ready = 0 from cycle 1 -> A held in main, B in skid, in_ready = 0. Raise out_ready for 4 cycles -> output order A, B, C, D with no loss or duplication.
- Full throughput: 100 beats with in_valid = out_ready = 1 -> one beat per cycle, latency 1, in_ready constantly 1.
- Flush: main and skid both full, assert flush with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1. The flush-cycle input never appears at the output.
- Async reset: assert rst between clock edges while 2 beats are held -> out_valid = 0 immediately, in_ready = 1. After release, the first new beat emerges one cycle after acceptance.
